// File: rtl/mycpu_pkg.sv
// mycpu_pkg: constants and helpers shared across the mycpu pipeline.
//   NUM_GPR   - architectural general-purpose register count
//   GPR_AW    - GPR address width
//   SB_CNT_W  - default width of the scoreboard in-flight-writer counter
//   SB_LAT_W  - default width of the issue latency field / ready timer
package mycpu_pkg;

  localparam int NUM_GPR  = 32;
  localparam int GPR_AW   = 5;
  localparam int SB_CNT_W = 2;
  localparam int SB_LAT_W = 2;

  typedef logic [GPR_AW-1:0] gpr_addr_t;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// sb_entry: scoreboard state for one GPR.
//   count   - number of issued, not yet retired writers of this register
//   timer   - cycles until the youngest writer's result can be forwarded
// Ports:
//   clk, reset        clock, async active-high reset
//   flush             discard all in-flight writers (overrides issue/retire)
//   issue_hit         an instruction writing this register issues this cycle
//   retire_hit        a write to this register retires in WB this cycle
//   lat               latency of the issuing writer
//   count             current in-flight-writer count
//   busy              count != 0
//   pending           result not yet forwardable (count != 0 && timer != 0)
module sb_entry
  import mycpu_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_hit,
  input  logic             retire_hit,
  input  logic [LAT_W-1:0] lat,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             pending
);

  logic [LAT_W-1:0] timer;
  logic             retire_ok;

  // A retire against an empty counter is an error handled by the top; it
  // must never underflow the count.
  assign retire_ok = retire_hit && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      timer <= '0;
    end else if (flush) begin
      count <= '0;
      timer <= '0;
    end else begin
      // Simultaneous issue and retire cancel out on the count.
      if (issue_hit && !retire_ok)
        count <= count + CNT_W'(1);
      else if (!issue_hit && retire_ok)
        count <= count - CNT_W'(1);

      // The youngest writer owns the timer; retire leaves it alone.
      if (issue_hit)
        timer <= lat;
      else if (timer != '0)
        timer <= timer - LAT_W'(1);
    end
  end

  assign busy    = (count != '0);
  assign pending = busy && (timer != '0);

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage RAW hazard scoreboard for GPRs 1..31.
// Tracks in-flight writers per register and a forwarding-ready timer, and
// holds issue back while any used source is not yet forwardable or the
// destination's writer counter is full.
// Ports:
//   clk, reset           clock, async active-high reset
//   issue_valid/ready    issue handshake (fires on valid && ready)
//   issue_we/dest/lat    destination write enable, GPR, result latency
//   issue_src_valid/src  per-port source used flag and GPR (5 bits per port)
//   wb_valid/wb_dest     GPR write retiring in WB
//   flush                discard all in-flight writers
//   src_hazard           per-port unresolved RAW hazard
//   busy_vec             bit r set while register r has in-flight writers
//   stall_cnt            saturating count of stalled issue cycles
//   sb_err               sticky: retire seen to a register with no writer
module id_scoreboard
  import mycpu_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = SB_CNT_W,
  parameter int LAT_W   = SB_LAT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic                      issue_we,
  input  logic [GPR_AW-1:0]         issue_dest,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC-1:0]        issue_src_valid,
  input  logic [GPR_AW*NUM_SRC-1:0] issue_src,
  input  logic                      wb_valid,
  input  logic [GPR_AW-1:0]         wb_dest,
  input  logic                      flush,
  output logic [NUM_SRC-1:0]        src_hazard,
  output logic [NUM_GPR-1:0]        busy_vec,
  output logic [31:0]               stall_cnt,
  output logic                      sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0]   cnt_q [NUM_GPR];
  logic [NUM_GPR-1:0] pend_vec;
  logic               issue_fire;
  logic               dest_full;
  logic               retire_empty;

  // GPR 0 is hardwired zero and never tracked.
  assign cnt_q[0]    = '0;
  assign busy_vec[0] = 1'b0;
  assign pend_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_GPR; r++) begin : g_entry
    logic issue_hit;
    logic retire_hit;

    assign issue_hit  = issue_fire && issue_we && (issue_dest == GPR_AW'(r));
    assign retire_hit = wb_valid && (wb_dest == GPR_AW'(r));

    sb_entry #(
      .CNT_W (CNT_W),
      .LAT_W (LAT_W)
    ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .issue_hit  (issue_hit),
      .retire_hit (retire_hit),
      .lat        (issue_lat),
      .count      (cnt_q[r]),
      .busy       (busy_vec[r]),
      .pending    (pend_vec[r])
    );
  end

  // pend_vec[0] is 0, so a source of $0 never reports a hazard.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [GPR_AW-1:0] src;
    assign src           = issue_src[GPR_AW*i +: GPR_AW];
    assign src_hazard[i] = issue_src_valid[i] && pend_vec[src];
  end

  assign dest_full    = issue_we && (issue_dest != '0) && (cnt_q[issue_dest] == MAX_CNT);
  assign issue_ready  = (src_hazard == '0) && !dest_full;
  assign issue_fire   = issue_valid && issue_ready;
  assign retire_empty = wb_valid && (wb_dest != '0) && (cnt_q[wb_dest] == '0);

  // Flush overrides the retire, so an empty-retire under flush is not flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      if (issue_valid && !issue_ready && !flush)
        stall_cnt <= sat_inc32(stall_cnt);
      if (retire_empty && !flush)
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 2;
  localparam int LAT_W   = 2;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 issue_we;
  logic [4:0]           issue_dest;
  logic [LAT_W-1:0]     issue_lat;
  logic [NUM_SRC-1:0]   issue_src_valid;
  logic [5*NUM_SRC-1:0] issue_src;
  logic                 wb_valid;
  logic [4:0]           wb_dest;
  logic                 flush;
  logic [NUM_SRC-1:0]   src_hazard;
  logic [31:0]          busy_vec;
  logic [31:0]          stall_cnt;
  logic                 sb_err;

  always #5 clk = ~clk;

  id_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W),
    .LAT_W   (LAT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_we        (issue_we),
    .issue_dest      (issue_dest),
    .issue_lat       (issue_lat),
    .issue_src_valid (issue_src_valid),
    .issue_src       (issue_src),
    .wb_valid        (wb_valid),
    .wb_dest         (wb_dest),
    .flush           (flush),
    .src_hazard      (src_hazard),
    .busy_vec        (busy_vec),
    .stall_cnt       (stall_cnt),
    .sb_err          (sb_err)
  );

  int          n_assert = 0;
  int          n_fail   = 0;

  // Reference model: per-register writer count and cycles-to-forwardable.
  int          m_cnt [32];
  int          m_tmr [32];
  longint      m_stall;
  bit          m_err;
  logic [31:0] saved_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_tmr[r] = 0;
    end
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  function automatic bit m_pend(input int r);
    return (r != 0) && (m_cnt[r] != 0) && (m_tmr[r] != 0);
  endfunction

  function automatic logic [NUM_SRC-1:0] m_haz();
    logic [NUM_SRC-1:0] h;
    logic [5*NUM_SRC-1:0] s;
    s = issue_src;
    for (int i = 0; i < NUM_SRC; i++)
      h[i] = issue_src_valid[i] && m_pend(int'(s[5*i +: 5]));
    return h;
  endfunction

  function automatic bit m_ready();
    return (m_haz() == '0) && !(issue_we && issue_dest != 0 && m_cnt[issue_dest] == MAXC);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_edge();
    bit rdy;
    int old_wb;
    rdy    = m_ready();
    old_wb = m_cnt[wb_dest];
    if (issue_valid && !rdy && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (flush) begin
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
        m_tmr[r] = 0;
      end
    end else begin
      for (int r = 1; r < 32; r++)
        if (m_tmr[r] != 0) m_tmr[r]--;
      if (issue_valid && rdy && issue_we && issue_dest != 0) begin
        m_cnt[issue_dest]++;
        m_tmr[issue_dest] = int'(issue_lat);
      end
      if (wb_valid && wb_dest != 0) begin
        if (old_wb != 0) m_cnt[wb_dest]--;
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("src_hazard", 32'(src_hazard), 32'(m_haz()));
    chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
    chk("busy_vec", busy_vec, m_busy());
    chk("stall_cnt", stall_cnt, m_stall[31:0]);
    chk("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  // Inputs are set 1 ns after a rising edge; outputs checked 1 ns later.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_we        = 1'b0;
    issue_dest      = '0;
    issue_lat       = '0;
    issue_src_valid = '0;
    issue_src       = '0;
    wb_valid        = 1'b0;
    wb_dest         = '0;
    flush           = 1'b0;
  endtask

  task automatic set_issue(input bit v, input bit we, input int dest, input int lat);
    issue_valid = v;
    issue_we    = we;
    issue_dest  = 5'(dest);
    issue_lat   = LAT_W'(lat);
  endtask

  task automatic set_src0(input int r);
    issue_src_valid = 2'b01;
    issue_src       = {5'd0, 5'(r)};
  endtask

  task automatic set_wb(input int r);
    wb_valid = 1'b1;
    wb_dest  = 5'(r);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #1;
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_err", 32'(sb_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ALU writer to $3 is forwardable immediately.
    set_issue(1, 1, 3, 0);
    cycle();
    idle(); set_issue(1, 0, 0, 0); set_src0(3);
    #1;
    chk("alu_hazard", 32'(src_hazard), 32'd0);
    chk("alu_ready", 32'(issue_ready), 32'd1);
    chk("alu_busy3", 32'(busy_vec[3]), 32'd1);
    cycle();

    // Load to $5 stalls the dependent for exactly one cycle.
    idle(); set_issue(1, 1, 5, 1);
    cycle();
    idle(); set_issue(1, 0, 0, 0); set_src0(5);
    #1;
    chk("load_hazard", 32'(src_hazard), 32'd1);
    chk("load_ready", 32'(issue_ready), 32'd0);
    cycle();
    chk("load_stall", stall_cnt, 32'd1);
    chk("load_hz_clr", 32'(src_hazard), 32'd0);
    cycle();

    // Writer counter on $7 saturates at MAX_CNT.
    idle();
    repeat (3) begin
      set_issue(1, 1, 7, 0);
      cycle();
    end
    #1;
    chk("full_ready", 32'(issue_ready), 32'd0);
    cycle();
    idle(); set_wb(7);
    cycle();
    idle(); set_issue(0, 1, 7, 0);
    #1;
    chk("full_wb_ready", 32'(issue_ready), 32'd1);
    cycle();

    // Same-cycle issue and retire on $9.
    idle(); set_issue(1, 1, 9, 0);
    cycle();
    idle(); set_issue(1, 1, 9, 2); set_wb(9);
    cycle();
    idle(); set_src0(9);
    #1;
    chk("same_busy9", 32'(busy_vec[9]), 32'd1);
    chk("same_hazard9", 32'(src_hazard), 32'd1);
    cycle();
    cycle();
    chk("same_hz9_clr", 32'(src_hazard), 32'd0);
    idle(); set_wb(9);
    cycle();
    chk("same_busy9_0", 32'(busy_vec[9]), 32'd0);

    // Retire to an idle register, then a flush while stalled.
    idle(); set_wb(4);
    cycle();
    chk("err_set", 32'(sb_err), 32'd1);
    idle(); set_issue(1, 1, 2, 3);
    cycle();
    set_issue(1, 1, 6, 3);
    cycle();
    idle(); set_issue(1, 0, 0, 0); set_src0(6); flush = 1'b1;
    saved_stall = stall_cnt;
    cycle();
    idle();
    #1;
    chk("flush_busy", busy_vec, 32'd0);
    chk("flush_stall", stall_cnt, saved_stall);
    chk("flush_err", 32'(sb_err), 32'd1);
    cycle();

    // Asynchronous reset in the middle of a stall.
    idle(); set_issue(1, 1, 8, 3);
    cycle();
    idle(); set_issue(1, 0, 0, 0); set_src0(8);
    cycle();
    reset = 1'b1;
    #1;
    chk("arst_busy", busy_vec, 32'd0);
    chk("arst_ready", 32'(issue_ready), 32'd1);
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_err", 32'(sb_err), 32'd0);
    model_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic on a small register window.
    for (int n = 0; n < 800; n++) begin
      issue_valid     = ($urandom_range(0, 3) != 0);
      issue_we        = ($urandom_range(0, 3) != 0);
      issue_dest      = 5'($urandom_range(0, 7));
      issue_lat       = LAT_W'($urandom_range(0, 3));
      issue_src_valid = NUM_SRC'($urandom_range(0, 3));
      issue_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_valid        = ($urandom_range(0, 2) == 0);
      wb_dest         = 5'($urandom_range(0, 7));
      flush           = ($urandom_range(0, 49) == 0);
      if (n == 400) begin
        reset = 1'b1;
        #1;
        chk("rnd_arst_busy", busy_vec, 32'd0);
        chk("rnd_arst_stall", stall_cnt, 32'd0);
        model_reset();
        reset = 1'b0;
      end
      cycle();
    end

    idle();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, number of source-register read ports checked per issued instruction.
REQ-002 The block SHALL have parameter CNT_W, default 2, width of the per-register in-flight-writer counter; MAX_CNT = 2^CNT_W-1.
REQ-003 The block SHALL have parameter LAT_W, default 2, width of the issue latency field and of the per-register ready timer.
REQ-004 The block SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port issue_valid  in  1  decode stage presents an instruction.
REQ-007 The block SHALL have port issue_ready  out  1  instruction may issue this cycle; it issues when issue_valid && issue_ready.
REQ-008 The block SHALL have port issue_we  in  1  instruction writes a GPR.
REQ-009 The block SHALL have port issue_dest  in  5  destination GPR.
REQ-010 The block SHALL have port issue_lat  in  LAT_W  cycles after issue until the result is forwardable (0 = ALU result, forwardable from EXE; 1 = load).
REQ-011 The block SHALL have port issue_src_valid  in  NUM_SRC  per-port source-used flag.
REQ-012 The block SHALL have port issue_src  in  5*NUM_SRC  source GPR numbers, port i at bits [5i+4:5i].
REQ-013 The block SHALL have port wb_valid  in  1  a GPR write retires in WB this cycle.
REQ-014 The block SHALL have port wb_dest  in  5  retiring destination.
REQ-015 The block SHALL have port flush  in  1  pipeline flush; all in-flight writers discarded.
REQ-016 The block SHALL have port src_hazard  out  NUM_SRC  per-port unresolved RAW hazard.
REQ-017 The block SHALL have port busy_vec  out  32  bit r set when count[r] != 0.
REQ-018 The block SHALL have port stall_cnt  out  32  saturating count of cycles with issue_valid && !issue_ready.
REQ-019 The block SHALL have port sb_err  out  1  sticky: retire to a register with count 0.

Function
REQ-020 Per GPR r in 1..31 the block SHALL keep count[r] (CNT_W) and timer[r] (LAT_W); GPR 0 SHALL never be tracked, count[0]=timer[0]=0.
REQ-021 src_hazard[i] SHALL be combinational: issue_src_valid[i] && src!=0 && count[src]!=0 && timer[src]!=0.
REQ-022 issue_ready SHALL be combinational: no src_hazard bit set && !(issue_we && issue_dest!=0 && count[issue_dest]==MAX_CNT).
REQ-023 On issue with issue_we && issue_dest!=0: count[dest] +1, timer[dest] loaded with issue_lat (latest writer wins).
REQ-024 Every cycle each timer not being loaded and nonzero SHALL decrement by 1.
REQ-025 On wb_valid && wb_dest!=0 && count!=0: count[wb_dest] -1; timer unaffected.
REQ-026 Issue and retire to the same register in one cycle: count unchanged, timer loaded with issue_lat.
REQ-027 Retire with count 0 or to GPR 0 SHALL change no count; count-0 retire to r!=0 sets sb_err until reset.
REQ-028 flush SHALL clear all counts and timers next edge, overriding issue and retire that cycle; stall_cnt and sb_err are kept.
REQ-029 stall_cnt SHALL increment when issue_valid && !issue_ready && !flush, holding at 0xFFFFFFFF.

Reset
REQ-030 While reset is high all counts, timers, stall_cnt and sb_err SHALL be 0 asynchronously; hence busy_vec=0, src_hazard reflects only inputs (all 0), issue_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight state; first edge after deassertion behaves as from empty.

Structure
REQ-032 GPR count (32), GPR address width (5) and default CNT_W/LAT_W SHALL be constants in the shared mycpu package/header.
REQ-033 One sub-module sb_entry (count + timer for a single register) SHALL be instantiated 31 times; port-wise hazard compare is generated over NUM_SRC.

Verification
REQ-034 Issue addu $3 (lat 0); next cycle src $3 -> src_hazard=0, issue_ready=1, busy_vec[3]=1.
REQ-035 Issue lw $5 (lat 1); next cycle src $5 -> src_hazard[0]=1, issue_ready=0, stall_cnt=1; following cycle hazard clears.
REQ-036 Issue to $7 three times (CNT_W=2) without retire -> count=3; fourth write to $7 -> issue_ready=0; wb $7 -> ready next cycle.
REQ-037 Same-cycle issue $9 (lat 2) and wb $9 with count 1 -> count stays 1, timer=2, busy_vec[9]=1.
REQ-038 wb $4 with count 0 -> sb_err=1 sticky; flush with $2,$6 busy -> busy_vec=0 next cycle, stall_cnt unchanged.
REQ-039 Assert reset mid-stall with $8 busy -> busy_vec=0, issue_ready=1, stall_cnt=0 immediately, without a clock edge.
